// File: rtl/eth_tx_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_axis_arbiter
// Brief    : Packet-granular 2:1 AXI-Stream arbiter feeding the 10G MAC TX
//            stream, with a per-packet beat limit and truncation flagging.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_axis_arbiter #(
    parameter int MAX_BEATS = 2048,
    parameter int PRIO_MODE = 0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic [31:0] s0_axis_tdata,
    input  logic [3:0]  s0_axis_tkeep,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    input  logic        s0_axis_tuser,
    output logic        s0_axis_tready,
    input  logic [31:0] s1_axis_tdata,
    input  logic [3:0]  s1_axis_tkeep,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    input  logic        s1_axis_tuser,
    output logic        s1_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [1:0]  grant_out,
    output logic [31:0] pkt_cnt0_out,
    output logic [31:0] pkt_cnt1_out,
    output logic [15:0] trunc_cnt_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT0 = 3'd1,
        ST_GRANT1 = 3'd2,
        ST_DROP0  = 3'd3,
        ST_DROP1  = 3'd4
    } state_t;

    localparam logic [15:0] C_LAST_BEAT = 16'(MAX_BEATS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_beat_cnt;
    logic        r_last_grant;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_next;
    logic [31:0] r_pkt_cnt0;
    logic [31:0] r_pkt_cnt1;
    logic [15:0] r_trunc_cnt;

    logic        w_sel1;
    logic [31:0] w_src_data;
    logic [3:0]  w_src_keep;
    logic        w_src_valid;
    logic        w_src_last;
    logic        w_src_user;
    logic        w_src_ready;
    logic        w_at_limit;
    logic        w_pick1;
    logic        w_beat_acc;
    logic        w_pkt_inc;
    logic        w_trunc;
    logic        w_lg_upd;

    // Owner of the current packet; only meaningful outside IDLE.
    assign w_sel1      = (r_state == ST_GRANT1) || (r_state == ST_DROP1);
    assign w_src_data  = w_sel1 ? s1_axis_tdata  : s0_axis_tdata;
    assign w_src_keep  = w_sel1 ? s1_axis_tkeep  : s0_axis_tkeep;
    assign w_src_valid = w_sel1 ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_src_last  = w_sel1 ? s1_axis_tlast  : s0_axis_tlast;
    assign w_src_user  = w_sel1 ? s1_axis_tuser  : s0_axis_tuser;
    assign w_at_limit  = (r_beat_cnt == C_LAST_BEAT);

    // With both requesting, round-robin favours the port not granted last.
    assign w_pick1 = (s0_axis_tvalid && s1_axis_tvalid)
                   ? ((PRIO_MODE == 0) && !r_last_grant)
                   : s1_axis_tvalid;

    assign s0_axis_tready = w_src_ready & ~w_sel1;
    assign s1_axis_tready = w_src_ready &  w_sel1;

    always_comb begin
        w_next_state  = r_state;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        w_src_ready   = 1'b0;
        w_beat_acc    = 1'b0;
        w_pkt_inc     = 1'b0;
        w_trunc       = 1'b0;
        w_lg_upd      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_in && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    w_next_state = w_pick1 ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                m_axis_tdata  = w_src_data;
                m_axis_tkeep  = w_src_keep;
                m_axis_tvalid = w_src_valid;
                m_axis_tlast  = w_src_last | w_at_limit;
                m_axis_tuser  = w_src_user | (w_at_limit & ~w_src_last);
                w_src_ready   = m_axis_tready;
                w_beat_acc    = w_src_valid & m_axis_tready;
                if (w_beat_acc && (w_src_last || w_at_limit)) begin
                    w_pkt_inc = 1'b1;
                    if (w_src_last) begin
                        w_next_state = ST_IDLE;
                        w_lg_upd     = 1'b1;
                    end else begin
                        w_next_state = w_sel1 ? ST_DROP1 : ST_DROP0;
                        w_trunc      = 1'b1;
                    end
                end
            end
            ST_DROP0, ST_DROP1: begin
                w_src_ready = 1'b1;
                if (w_src_valid && w_src_last) begin
                    w_next_state = ST_IDLE;
                    w_lg_upd     = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant_next = 2'b00;
        case (w_next_state)
            ST_GRANT0, ST_DROP0: w_grant_next = 2'b01;
            ST_GRANT1, ST_DROP1: w_grant_next = 2'b10;
            default:             w_grant_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_beat_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_grant_next;
            if (r_state == ST_IDLE) begin
                r_beat_cnt <= '0;
            end else if (w_beat_acc) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (w_lg_upd) begin
                r_last_grant <= w_sel1;
            end
            if (w_pkt_inc && !w_sel1) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
            end
            if (w_pkt_inc && w_sel1) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
            end
            if (w_trunc && (r_trunc_cnt != 16'hFFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign grant_out     = r_grant;
    assign pkt_cnt0_out  = r_pkt_cnt0;
    assign pkt_cnt1_out  = r_pkt_cnt1;
    assign trunc_cnt_out = r_trunc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_axis_arbiter
// Brief    : Scoreboard bench for eth_tx_axis_arbiter (round-robin and
//            fixed-priority instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_axis_arbiter;

    localparam int MAXA        = 16;
    localparam int MAXB        = 8;
    localparam int TIMEOUT_CYC = 60000;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        enable_in;
    logic [31:0] s0_axis_tdata;
    logic [3:0]  s0_axis_tkeep;
    logic        s0_axis_tvalid;
    logic        s0_axis_tlast;
    logic        s0_axis_tuser;
    logic        s0_axis_tready;
    logic [31:0] s1_axis_tdata;
    logic [3:0]  s1_axis_tkeep;
    logic        s1_axis_tvalid;
    logic        s1_axis_tlast;
    logic        s1_axis_tuser;
    logic        s1_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic [1:0]  grant_out;
    logic [31:0] pkt_cnt0_out;
    logic [31:0] pkt_cnt1_out;
    logic [15:0] trunc_cnt_out;

    logic        b_enable;
    logic [31:0] b_s0_tdata;
    logic [3:0]  b_s0_tkeep;
    logic        b_s0_tvalid;
    logic        b_s0_tlast;
    logic        b_s0_tuser;
    logic        b_s0_tready;
    logic [31:0] b_s1_tdata;
    logic [3:0]  b_s1_tkeep;
    logic        b_s1_tvalid;
    logic        b_s1_tlast;
    logic        b_s1_tuser;
    logic        b_s1_tready;
    logic [31:0] b_m_tdata;
    logic [3:0]  b_m_tkeep;
    logic        b_m_tvalid;
    logic        b_m_tlast;
    logic        b_m_tuser;
    logic        b_m_tready;
    logic [1:0]  b_grant;
    logic [31:0] b_cnt0;
    logic [31:0] b_cnt1;
    logic [15:0] b_trunc;

    eth_tx_axis_arbiter #(.MAX_BEATS(MAXA), .PRIO_MODE(0)) dut_a (
        .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
        .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
        .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant_out(grant_out), .pkt_cnt0_out(pkt_cnt0_out),
        .pkt_cnt1_out(pkt_cnt1_out), .trunc_cnt_out(trunc_cnt_out)
    );

    eth_tx_axis_arbiter #(.MAX_BEATS(MAXB), .PRIO_MODE(1)) dut_b (
        .clk_in(clk), .reset_in(reset_in), .enable_in(b_enable),
        .s0_axis_tdata(b_s0_tdata), .s0_axis_tkeep(b_s0_tkeep),
        .s0_axis_tvalid(b_s0_tvalid), .s0_axis_tlast(b_s0_tlast),
        .s0_axis_tuser(b_s0_tuser), .s0_axis_tready(b_s0_tready),
        .s1_axis_tdata(b_s1_tdata), .s1_axis_tkeep(b_s1_tkeep),
        .s1_axis_tvalid(b_s1_tvalid), .s1_axis_tlast(b_s1_tlast),
        .s1_axis_tuser(b_s1_tuser), .s1_axis_tready(b_s1_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
        .m_axis_tuser(b_m_tuser), .m_axis_tready(b_m_tready),
        .grant_out(b_grant), .pkt_cnt0_out(b_cnt0),
        .pkt_cnt1_out(b_cnt1), .trunc_cnt_out(b_trunc)
    );

    int    n_checks = 0;
    int    n_err    = 0;
    int    cyc      = 0;
    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    start_port[$];
    int    start_cyc[$];
    int    end_cyc;
    int    acc[2];
    int    pkt_id[2];
    int    exp_pkt[2];
    int    exp_trunc;
    bit    mon_en;
    bit    rdy_rand;
    bit    in_pkt;
    int    owner;
    int    mp;
    beat_t got;
    beat_t want;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_src(input int port, input bit v, input beat_t b);
        if (port == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = b.data; s0_axis_tkeep = b.keep;
            s0_axis_tlast = b.last; s0_axis_tuser = b.user;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = b.data; s1_axis_tkeep = b.keep;
            s1_axis_tlast = b.last; s1_axis_tuser = b.user;
        end
    endtask

    // Issue one packet: record the expected (possibly truncated) output, then drive it.
    task automatic send_pkt(input int port, input int len, input int bub);
        beat_t src[$];
        beat_t b;
        beat_t e;
        int    id;
        int    k;
        bit    hs;
        id = pkt_id[port];
        pkt_id[port]++;
        for (int i = 0; i < len; i++) begin
            b.data = {port == 1, 15'(id), 16'(i)};
            b.keep = (i == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            b.last = (i == len - 1);
            b.user = 1'($urandom_range(0, 1));
            src.push_back(b);
            if (i < MAXA) begin
                e      = b;
                e.last = b.last || (i == MAXA - 1);
                e.user = b.user || ((i == MAXA - 1) && (len > MAXA));
                if (port == 0) exp_q0.push_back(e);
                else           exp_q1.push_back(e);
            end
        end
        exp_pkt[port]++;
        if (len > MAXA) exp_trunc++;
        k = 0;
        while (k < len) begin
            if (bub > 0 && $urandom_range(0, 99) < bub) set_src(port, 1'b0, src[k]);
            else                                         set_src(port, 1'b1, src[k]);
            @(negedge clk);
            hs = (port == 0) ? (s0_axis_tvalid && s0_axis_tready) : (s1_axis_tvalid && s1_axis_tready);
            @(posedge clk); #1;
            if (hs) begin
                k++;
                acc[port]++;
            end
        end
        set_src(port, 1'b0, '0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the per-port expectation whenever the MAC accepts a beat.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_axis_tvalid && m_axis_tready) begin
                mp  = m_axis_tdata[31] ? 1 : 0;
                got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
                chk(grant_out == (mp == 1 ? 2'b10 : 2'b01), "grant_during_beat", 64'(grant_out), 64'(mp == 1 ? 2 : 1));
                if (!in_pkt) begin
                    in_pkt = 1'b1;
                    owner  = mp;
                    start_port.push_back(mp);
                    start_cyc.push_back(cyc);
                end else begin
                    chk(mp == owner, "no_interleave", 64'(mp), 64'(owner));
                end
                if ((mp == 0 && exp_q0.size() == 0) || (mp == 1 && exp_q1.size() == 0)) begin
                    chk(1'b0, "unexpected_beat", 64'(got), 64'(0));
                end else begin
                    want = (mp == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
                    chk(got == want, "beat", 64'(got), 64'(want));
                end
                if (m_axis_tlast) begin
                    in_pkt  = 1'b0;
                    end_cyc = cyc;
                end
            end
            if (grant_out == 2'b00) begin
                chk(!m_axis_tvalid && !s0_axis_tready && !s1_axis_tready, "idle_outputs",
                    64'({m_axis_tvalid, s0_axis_tready, s1_axis_tready}), 64'(0));
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYC) @(posedge clk);
        n_checks++;
        n_err++;
        $display("FAIL watchdog: actual=timeout required=completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int  base0;
        int  p0k;
        int  j;
        int  out_n;
        int  dropped;
        bit  hs;
        bit  s1_seen;
        beat_t d;

        reset_in = 1'b1; enable_in = 1'b1; mon_en = 1'b0; rdy_rand = 1'b0; in_pkt = 1'b0;
        owner = 0; end_cyc = 0; exp_trunc = 0;
        acc = '{0, 0}; pkt_id = '{0, 0}; exp_pkt = '{0, 0};
        set_src(0, 1'b0, '0);
        set_src(1, 1'b0, '0);
        b_enable = 1'b1; b_m_tready = 1'b1;
        b_s0_tdata = '0; b_s0_tkeep = 4'hF; b_s0_tvalid = 1'b0; b_s0_tlast = 1'b0; b_s0_tuser = 1'b0;
        b_s1_tdata = '0; b_s1_tkeep = 4'hF; b_s1_tvalid = 1'b0; b_s1_tlast = 1'b0; b_s1_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(grant_out == 2'b00 && b_grant == 2'b00, "reset_grant", 64'({grant_out, b_grant}), 64'(0));
        chk(!m_axis_tvalid && m_axis_tdata == 32'd0 && !s0_axis_tready && !s1_axis_tready, "reset_outputs",
            64'({m_axis_tvalid, m_axis_tdata, s0_axis_tready, s1_axis_tready}), 64'(0));
        chk(pkt_cnt0_out == 0 && pkt_cnt1_out == 0 && trunc_cnt_out == 0, "reset_counters",
            64'({pkt_cnt0_out, trunc_cnt_out}), 64'(0));
        reset_in = 1'b0;
        mon_en   = 1'b1;
        @(posedge clk); #1;

        // Round-robin: both ports continuously valid, 4-beat packets.
        start_port.delete(); start_cyc.delete();
        fork
            for (int i = 0; i < 4; i++) send_pkt(0, 4, 0);
            for (int i = 0; i < 4; i++) send_pkt(1, 4, 0);
        join
        chk(start_port.size() == 8, "rr_pkt_count", 64'(start_port.size()), 64'(8));
        for (int i = 0; i < start_port.size() && i < 8; i++) begin
            chk(start_port[i] == i % 2, "rr_order", 64'(start_port[i]), 64'(i % 2));
            if (i > 0) chk(start_cyc[i] - start_cyc[i-1] == 5, "rr_gap", 64'(start_cyc[i] - start_cyc[i-1]), 64'(5));
        end
        chk(pkt_cnt0_out == exp_pkt[0], "rr_cnt0", 64'(pkt_cnt0_out), 64'(exp_pkt[0]));
        chk(pkt_cnt1_out == exp_pkt[1], "rr_cnt1", 64'(pkt_cnt1_out), 64'(exp_pkt[1]));

        // Single 16-beat packet on port 0.
        start_port.delete(); start_cyc.delete();
        send_pkt(0, 16, 0);
        chk(start_port.size() == 1, "single_pkt_count", 64'(start_port.size()), 64'(1));
        if (start_cyc.size() > 0) chk(end_cyc - start_cyc[0] == 15, "single_consecutive", 64'(end_cyc - start_cyc[0]), 64'(15));
        chk(grant_out == 2'b00, "single_grant_after", 64'(grant_out), 64'(0));
        chk(pkt_cnt0_out == exp_pkt[0], "single_cnt0", 64'(pkt_cnt0_out), 64'(exp_pkt[0]));

        // Random lengths (some over the limit), random bubbles and MAC backpressure.
        rdy_rand = 1'b1;
        fork
            for (int i = 0; i < 100; i++) send_pkt(0, int'($urandom_range(1, 20)), 30);
            for (int i = 0; i < 100; i++) send_pkt(1, int'($urandom_range(1, 20)), 30);
        join
        rdy_rand = 1'b0;
        chk(exp_q0.size() == 0, "rand_q0_drained", 64'(exp_q0.size()), 64'(0));
        chk(exp_q1.size() == 0, "rand_q1_drained", 64'(exp_q1.size()), 64'(0));
        chk(pkt_cnt0_out == exp_pkt[0], "rand_cnt0", 64'(pkt_cnt0_out), 64'(exp_pkt[0]));
        chk(pkt_cnt1_out == exp_pkt[1], "rand_cnt1", 64'(pkt_cnt1_out), 64'(exp_pkt[1]));
        chk(trunc_cnt_out == 16'(exp_trunc), "rand_trunc", 64'(trunc_cnt_out), 64'(exp_trunc));

        // enable_in dropped mid-packet: packet completes, then nothing is granted.
        base0 = acc[0];
        fork
            send_pkt(0, 10, 0);
            begin
                for (int c = 0; c < 200 && acc[0] < base0 + 3; c++) begin
                    @(posedge clk); #1;
                end
                enable_in = 1'b0;
            end
        join
        repeat (2) begin @(posedge clk); #1; end
        d = '{data: 32'h0000_0000, keep: 4'hF, last: 1'b0, user: 1'b0};
        set_src(0, 1'b1, d);
        d.data = 32'h8000_0000;
        set_src(1, 1'b1, d);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk(!s0_axis_tready && !s1_axis_tready && grant_out == 2'b00 && !m_axis_tvalid, "disabled_idle",
            64'({s0_axis_tready, s1_axis_tready, grant_out, m_axis_tvalid}), 64'(0));
        chk(exp_q0.size() == 0, "enable_all_beats", 64'(exp_q0.size()), 64'(0));
        chk(pkt_cnt0_out == exp_pkt[0], "enable_cnt0", 64'(pkt_cnt0_out), 64'(exp_pkt[0]));
        @(posedge clk); #1;

        // Fixed priority instance: port 0 keeps winning while it stays valid.
        b_s1_tdata = {1'b1, 15'd0, 16'd0}; b_s1_tlast = 1'b0; b_s1_tvalid = 1'b1;
        p0k = 0;
        b_s0_tdata = 32'd0; b_s0_tlast = 1'b0; b_s0_tvalid = 1'b1;
        s1_seen = 1'b0;
        for (int c = 0; c < 400 && p0k < 32; c++) begin
            @(negedge clk);
            hs = b_s0_tvalid && b_s0_tready;
            if (b_s1_tready) s1_seen = 1'b1;
            if (b_m_tvalid && b_m_tready) chk(b_m_tdata == {16'd0, 16'(p0k)}, "prio_port0_beat", 64'(b_m_tdata), 64'(p0k));
            @(posedge clk); #1;
            if (hs) p0k++;
            b_s0_tdata  = {16'd0, 16'(p0k)};
            b_s0_tlast  = (p0k % 4 == 3);
            b_s0_tvalid = (p0k < 32);
        end
        chk(b_cnt0 == 32'd8, "prio_cnt0", 64'(b_cnt0), 64'(8));
        chk(b_cnt1 == 32'd0, "prio_cnt1", 64'(b_cnt1), 64'(0));
        chk(!s1_seen, "prio_s1_blocked", 64'(s1_seen), 64'(0));

        // Port 1 now sends a 12-beat packet against an 8-beat limit.
        j = 0; out_n = 0; dropped = 0;
        for (int c = 0; c < 100 && j < 12; c++) begin
            @(negedge clk);
            hs = b_s1_tvalid && b_s1_tready;
            if (b_m_tvalid && b_m_tready) begin
                out_n++;
                chk(b_m_tdata == {1'b1, 15'd0, 16'(j)}, "trunc_data", 64'(b_m_tdata), 64'({1'b1, 15'd0, 16'(j)}));
                chk(b_m_tlast == (out_n == 8) && b_m_tuser == (out_n == 8), "trunc_last_user",
                    64'({b_m_tlast, b_m_tuser}), 64'(out_n == 8 ? 3 : 0));
            end else if (hs) begin
                dropped++;
            end
            @(posedge clk); #1;
            if (hs) j++;
            b_s1_tdata  = {1'b1, 15'd0, 16'(j)};
            b_s1_tlast  = (j == 11);
            b_s1_tvalid = (j < 12);
        end
        chk(out_n == 8, "trunc_beats_out", 64'(out_n), 64'(8));
        chk(dropped == 4, "trunc_beats_dropped", 64'(dropped), 64'(4));
        chk(b_trunc == 16'd1, "trunc_cnt", 64'(b_trunc), 64'(1));
        chk(b_cnt1 == 32'd1, "trunc_pkt_cnt1", 64'(b_cnt1), 64'(1));
        chk(b_grant == 2'b00, "trunc_grant_after", 64'(b_grant), 64'(0));

        // Asynchronous reset in the middle of a port 1 packet.
        mon_en = 1'b0;
        set_src(0, 1'b0, '0);
        enable_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(m_axis_tvalid == 1'b1, "pre_reset_busy", 64'(m_axis_tvalid), 64'(1));
        #2 reset_in = 1'b1;
        #1;
        chk(!m_axis_tvalid && m_axis_tdata == 32'd0 && !m_axis_tlast && !s1_axis_tready && grant_out == 2'b00,
            "async_reset_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s1_axis_tready, grant_out}), 64'(0));
        chk(pkt_cnt0_out == 0 && pkt_cnt1_out == 0 && trunc_cnt_out == 0, "async_reset_counters",
            64'({pkt_cnt1_out, trunc_cnt_out}), 64'(0));
        @(posedge clk); #1;
        set_src(1, 1'b0, '0);
        reset_in = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_axis_arbiter.md
# eth_tx_axis_arbiter

Packet-granular two-input AXI-Stream arbiter that shares the single 10G Ethernet MAC TX stream (32-bit, tx_clk_out domain) between the XG-PON loopback path (port 0) and a test/PRBS burst source (port 1). It sits between those sources and the MAC TX AXIS interface. It never interleaves beats from different packets. Packets that exceed a length limit are truncated with an error flag.

## Interface
Parameters:
- MAX_BEATS, 2048 — maximum beats per packet (32-bit beats); range 2..65535.
- PRIO_MODE, 0 — 0 = round-robin; 1 = fixed priority, port 0 wins.

Ports:
- clk_in  in  1  MAC TX user clock; all logic on rising edge.
- reset_in  in  1  Asynchronous, active-high reset.
- enable_in  in  1  1 = grant new packets; 0 = finish current packet, then grant nothing.
- s0_axis_tdata / tkeep / tvalid / tlast / tuser  in  32/4/1/1/1  Port 0 (XG-PON loopback) slave stream.
- s0_axis_tready  out  1  Port 0 ready.
- s1_axis_tdata / tkeep / tvalid / tlast / tuser  in  32/4/1/1/1  Port 1 (test source) slave stream.
- s1_axis_tready  out  1  Port 1 ready.
- m_axis_tdata / tkeep / tvalid / tlast / tuser  out  32/4/1/1/1  Master stream to MAC TX.
- m_axis_tready  in  1  MAC ready.
- grant_out  out  2  One-hot current owner (bit0 = port 0); 00 when idle.
- pkt_cnt0_out, pkt_cnt1_out  out  32 each  Packets forwarded per port; wraps at 2^32.
- trunc_cnt_out  out  16  Truncated packets (both ports); saturates at 0xFFFF.

## Operation
- States: IDLE, GRANT0, GRANT1, DROP0, DROP1.
- IDLE:
  - Both s*_tready = 0; m_axis_tvalid = 0.
  - If enable_in = 1 and at least one s*_tvalid = 1, move to GRANTx on the next edge.
  - Choice when both ports are valid:
    - PRIO_MODE = 1: port 0.
    - PRIO_MODE = 0: the port not granted last. last_grant resets to port 1, so port 0 wins first.
- GRANTx:
  - Combinational pass-through: m_axis_* = sx_axis_*; sx_tready = m_axis_tready; the other port's tready = 0.
  - A beat is accepted when m_axis_tvalid & m_axis_tready.
  - beat_cnt (16 bit) clears on entering GRANTx and increments on each accepted beat.
  - Accepted beat with tlast = 1: pkt_cntx++, update last_grant, go to IDLE.
  - Accepted beat with beat_cnt = MAX_BEATS-1 and source tlast = 0 (truncation):
    - Drive m_axis_tlast = 1 and m_axis_tuser = 1 on that beat.
    - pkt_cntx++, trunc_cnt++, go to DROPx.
  - If source tlast = 1 on beat MAX_BEATS-1, this is a normal end with no truncation.
- DROPx:
  - sx_tready = 1; m_axis_tvalid = 0; discard beats.
  - On an accepted source beat with tlast = 1, update last_grant and go to IDLE.
- enable_in is sampled only in IDLE. Deasserting it mid-packet does not cut the packet.
- Reset (asynchronous, any state): state = IDLE, beat_cnt = 0, last_grant = port 1, all counters = 0.
  - Outputs in reset: all tready = 0, m_axis_tvalid = 0, tdata/tkeep/tlast/tuser = 0, grant_out = 00.
  - A packet cut by reset is not counted. Sources must restart it.

## Timing
- Data latency: 0 cycles (combinational mux). tready path: 0 cycles from m_axis_tready.
- Arbitration costs exactly 1 IDLE cycle between packets. Maximum throughput is N/(N+1) beats per cycle for N-beat packets.
- In IDLE, m_axis_tdata/tkeep/tlast/tuser = 0.
- grant_out is registered; it equals the state one-hot: GRANT0/DROP0 → 01, GRANT1/DROP1 → 10.
- Counters update on the clock edge after the qualifying beat.
- Source tvalid drop mid-packet: hold the state and insert bubbles. m_axis_tvalid follows the source.
- The MAC may hold tready low indefinitely. No timeout applies.

## Test plan
- Single port 0 packet, 16 beats, m_tready = 1 → 16 consecutive beats out unchanged, tlast on beat 16; pkt_cnt0 = 1; grant_out 01 then 00.
- Both ports continuously valid, 4-beat packets, PRIO_MODE = 0 → order 0,1,0,1; one idle cycle between packets; after 8 packets pkt_cnt0 = 4 and pkt_cnt1 = 4.
- Same stimulus, PRIO_MODE = 1 → port 0 only; pkt_cnt1 = 0 while port 0 stays valid.
- MAX_BEATS = 8, port 1 sends a 12-beat packet → 8 beats out, beat 8 has tlast = 1 and tuser = 1; port 1 tready stays 1 for 4 further beats, with m_tvalid = 0; trunc_cnt = 1, pkt_cnt1 = 1.
- Random m_tready (50%) and random source bubbles, 100 packets per port → output stream byte-identical per port, no interleaving, counters = 100 each.
- enable_in → 0 at beat 3 of a 10-beat packet → all 10 beats delivered, then IDLE with tready = 0. reset_in pulse mid-packet → m_tvalid = 0 and counters = 0 immediately (asynchronous).
